// File: rtl/stream_fifo_ram_if.sv
// Valid/ready stream bundle for stream_fifo_ram: s_* is the write side, m_* the read side.
// slave = the FIFO's view, master = the producer/consumer environment's view.
interface stream_fifo_ram_if #(
  parameter int C_DATA_WIDTH = 64
);
  logic                    s_valid;
  logic                    s_ready;
  logic [C_DATA_WIDTH-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [C_DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/stream_fifo_ram.sv
// Block-RAM stream FIFO with registered read and a 2-entry prefetch stage (output reg + skid).
// Define STREAM_FIFO_LEVEL_EN to add the registered level and almost_full outputs.
module stream_fifo_ram #(
  parameter int C_DATA_WIDTH         = 64,
  parameter int C_ADDR_SIZE          = 9,
  parameter int C_ALMOST_FULL_MARGIN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_fifo_ram_if.slave     bus
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [C_ADDR_SIZE:0] level,
  output logic                 almost_full
`endif
);

  localparam int DEPTH = 2 ** C_ADDR_SIZE;
  localparam logic [C_ADDR_SIZE:0] DEPTH_C = {1'b1, {C_ADDR_SIZE{1'b0}}};

  if (C_ALMOST_FULL_MARGIN < 0 || C_ALMOST_FULL_MARGIN > DEPTH) begin : g_margin_chk
    $error("stream_fifo_ram: C_ALMOST_FULL_MARGIN out of range");
  end

  logic [C_DATA_WIDTH-1:0] mem [DEPTH];

  logic [C_ADDR_SIZE:0]    count;
  logic [C_ADDR_SIZE:0]    count_nxt;
  logic [C_ADDR_SIZE:0]    ram_cnt;
  logic [C_ADDR_SIZE-1:0]  wr_ptr;
  logic [C_ADDR_SIZE-1:0]  rd_ptr;
  logic                    s_ready_q;

  logic                    vld_p1;
  logic [C_DATA_WIDTH-1:0] rd_data_p1;
  logic                    skid_vld;
  logic [C_DATA_WIDTH-1:0] skid_data;
  logic                    out_vld;
  logic [C_DATA_WIDTH-1:0] out_data;

  logic                    push;
  logic                    pop;
  logic                    rd_en;
  logic                    out_free;
  logic [1:0]              occ;

  assign push      = bus.s_valid & s_ready_q;
  assign pop       = out_vld & bus.m_ready;
  assign out_free  = ~out_vld | bus.m_ready;
  assign count_nxt = count + {{C_ADDR_SIZE{1'b0}}, push} - {{C_ADDR_SIZE{1'b0}}, pop};

  // Stage occupancy after this edge's pop; a read is only issued for words already in the RAM,
  // so a same-cycle write never races the read of that address.
  assign occ   = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, vld_p1} - {1'b0, pop};
  assign rd_en = (ram_cnt != '0) && (occ < 2'd2);

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = out_vld;
  assign bus.m_data  = out_data;

  // Stage p0 -> p1: RAM write and registered read
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.s_data;
    if (rd_en)
      rd_data_p1 <= mem[rd_ptr];
    if (vld_p1)
      skid_data <= rd_data_p1;
  end

  // Stage p1 -> output: control, pointers and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      ram_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_q <= 1'b0;
      vld_p1    <= 1'b0;
      skid_vld  <= 1'b0;
      out_vld   <= 1'b0;
      out_data  <= '0;
    end else begin
      count     <= count_nxt;
      s_ready_q <= (count_nxt < DEPTH_C);
      ram_cnt   <= ram_cnt + {{C_ADDR_SIZE{1'b0}}, push} - {{C_ADDR_SIZE{1'b0}}, rd_en};
      if (push)
        wr_ptr <= wr_ptr + {{(C_ADDR_SIZE-1){1'b0}}, 1'b1};
      if (rd_en)
        rd_ptr <= rd_ptr + {{(C_ADDR_SIZE-1){1'b0}}, 1'b1};
      vld_p1 <= rd_en;
      if (out_free) begin
        if (skid_vld) begin
          out_data <= skid_data;
          out_vld  <= 1'b1;
          skid_vld <= vld_p1;
        end else if (vld_p1) begin
          out_data <= rd_data_p1;
          out_vld  <= 1'b1;
        end else begin
          out_vld  <= 1'b0;
        end
      end else if (vld_p1) begin
        skid_vld <= 1'b1;
      end
    end
  end

`ifdef STREAM_FIFO_LEVEL_EN
  localparam logic [C_ADDR_SIZE:0] AF_TH = DEPTH_C - C_ALMOST_FULL_MARGIN[C_ADDR_SIZE:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= count_nxt;
      almost_full <= (count_nxt >= AF_TH);
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo_ram.sv
// Scoreboard bench for stream_fifo_ram (default 64-bit x 512); level checks when STREAM_FIFO_LEVEL_EN is defined.
`timescale 1ns/1ps
module tb_stream_fifo_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] sb [$];

  stream_fifo_ram_if #(.C_DATA_WIDTH(64)) bus ();

`ifdef STREAM_FIFO_LEVEL_EN
  logic [9:0] level;
  logic       almost_full;
`endif

  stream_fifo_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; records accepted words in the scoreboard and reports the popped word.
  task automatic cycle(output bit pushed, output bit popped, output logic [63:0] pdata);
    pushed = bus.s_valid & bus.s_ready;
    popped = bus.m_valid & bus.m_ready;
    pdata  = bus.m_data;
    if (pushed) sb.push_back(bus.s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit pu, po; logic [63:0] d;
    rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(pu, po, d);
      total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    end
    rst = 1'b0;
    cycle(pu, po, d);
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_s_ready: got %b want 1", bus.s_ready); end
    total++; if (bus.m_data !== 64'h0) begin bad++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
`ifdef STREAM_FIFO_LEVEL_EN
    total++; if (level !== 10'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", almost_full); end
`endif
  endtask

  task automatic test_single();
    bit pu, po; logic [63:0] d, exp;
    bus.s_valid = 1'b1; bus.s_data = 64'h0123456789ABCDEF; bus.m_ready = 1'b0;
    cycle(pu, po, d);
    total++; if (pu !== 1'b1) begin bad++; $display("FAIL single_accept: got %b want 1", pu); end
    bus.s_valid = 1'b0;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_lat_k: got %b want 0", bus.m_valid); end
    cycle(pu, po, d);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_lat_k1: got %b want 0", bus.m_valid); end
    cycle(pu, po, d);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL single_lat_k2: got %b want 1", bus.m_valid); end
`ifdef STREAM_FIFO_LEVEL_EN
    total++; if (level !== 10'd1) begin bad++; $display("FAIL single_level: got %0d want 1", level); end
`endif
    bus.m_ready = 1'b1;
    cycle(pu, po, d);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    total++; if (po !== 1'b1 || d !== exp) begin bad++; $display("FAIL single_data: got %h want %h", d, exp); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_empty: got %b want 0", bus.m_valid); end
    total++; if (bus.m_data !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL single_hold: got %h want 0123456789abcdef", bus.m_data); end
    bus.m_ready = 1'b0;
`ifdef STREAM_FIFO_LEVEL_EN
    total++; if (level !== 10'd0) begin bad++; $display("FAIL single_level0: got %0d want 0", level); end
`endif
  endtask

  task automatic test_fill();
    bit pu, po; logic [63:0] d, exp;
    int acc = 0;
    int got = 0;
    bus.m_ready = 1'b0; bus.s_valid = 1'b1;
    for (int c = 0; c < 700 && acc < 512; c++) begin
      bus.s_data = 64'(acc);
      cycle(pu, po, d);
      if (pu) begin
        acc++;
`ifdef STREAM_FIFO_LEVEL_EN
        total++; if (level !== 10'(acc)) begin bad++; $display("FAIL fill_level: got %0d want %0d", level, acc); end
        total++; if (almost_full !== (acc >= 504)) begin bad++; $display("FAIL fill_af: got %b want %b at %0d", almost_full, (acc >= 504), acc); end
`endif
      end
    end
    total++; if (acc !== 512) begin bad++; $display("FAIL fill_count: got %0d want 512", acc); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got %b want 0", bus.s_ready); end
    bus.s_data = 64'd512;
    for (int c = 0; c < 5; c++) begin
      cycle(pu, po, d);
      total++; if (pu !== 1'b0) begin bad++; $display("FAIL fill_holdoff: got %b want 0", pu); end
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    cycle(pu, po, d);
    if (po) begin
      exp = sb.pop_front(); got++;
      total++; if (d !== exp) begin bad++; $display("FAIL drain_first: got %h want %h", d, exp); end
    end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL drain_s_ready: got %b want 1", bus.s_ready); end
    for (int c = 0; c < 700 && sb.size() > 0; c++) begin
      cycle(pu, po, d);
      if (po) begin
        exp = sb.pop_front(); got++;
        total++; if (d !== exp) begin bad++; $display("FAIL drain_data: got %h want %h", d, exp); end
      end
    end
    total++; if (got !== 512) begin bad++; $display("FAIL drain_count: got %0d want 512", got); end
    bus.m_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_back_to_back();
    bit pu, po; logic [63:0] d, exp;
    int sent = 0, got = 0, first = -1, gaps = 0, stalls = 0;
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    for (int c = 0; c < 2100 && got < 2000; c++) begin
      bus.s_valid = (sent < 2000);
      bus.s_data  = 64'h5A00_0000_0000_0000 + 64'(sent);
      cycle(pu, po, d);
      if (bus.s_valid === 1'b0 && sent < 2000) stalls++;
      if (pu) sent++;
      else if (sent < 2000) stalls++;
      if (po) begin
        if (first < 0) first = c;
        exp = sb.pop_front(); got++;
        total++; if (d !== exp) begin bad++; $display("FAIL stream_data: got %h want %h", d, exp); end
      end else if (first >= 0) gaps++;
    end
    total++; if (first !== 3) begin bad++; $display("FAIL stream_latency: got %0d want 3", first); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    total++; if (stalls !== 0) begin bad++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
    total++; if (got !== 2000) begin bad++; $display("FAIL stream_count: got %0d want 2000", got); end
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
  endtask

  task automatic test_random();
    bit pu, po; logic [63:0] d, exp, held;
    bit stalled = 0;
    int sent = 0, got = 0;
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      if (sent >= 10000) begin
        bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      end else begin
        bus.s_valid = $urandom_range(0, 1);
        bus.m_ready = $urandom_range(0, 1);
        bus.s_data  = {$urandom, $urandom};
      end
      if (stalled) begin
        total++; if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin bad++; $display("FAIL rand_stable: got %b/%h want 1/%h", bus.m_valid, bus.m_data, held); end
      end
      stalled = bus.m_valid & ~bus.m_ready;
      held    = bus.m_data;
      cycle(pu, po, d);
      if (pu) sent++;
      if (po) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        got++;
        total++; if (d !== exp) begin bad++; $display("FAIL rand_data: got %h want %h", d, exp); end
      end
    end
    total++; if (got !== 10000) begin bad++; $display("FAIL rand_count: got %0d want 10000", got); end
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit pu, po; logic [63:0] d;
    int acc = 0;
    bit seen = 0;
    bus.m_ready = 1'b0; bus.s_valid = 1'b1;
    for (int c = 0; c < 200 && acc < 100; c++) begin
      bus.s_data = 64'hDEAD_0000 + 64'(acc);
      cycle(pu, po, d);
      if (pu) acc++;
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    cycle(pu, po, d);
    sb.delete();
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid: got %b want 0", bus.m_valid); end
    rst = 1'b0;
    cycle(pu, po, d);
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL mid_s_ready: got %b want 1", bus.s_ready); end
    bus.s_valid = 1'b1; bus.s_data = 64'hAA;
    cycle(pu, po, d);
    bus.s_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.m_valid === 1'b1) seen = 1;
      else cycle(pu, po, d);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_timeout: got %b want 1", seen); end
`ifdef STREAM_FIFO_LEVEL_EN
    total++; if (level !== 10'd1) begin bad++; $display("FAIL mid_level: got %0d want 1", level); end
`endif
    bus.m_ready = 1'b1;
    cycle(pu, po, d);
    total++; if (po !== 1'b1 || d !== 64'hAA) begin bad++; $display("FAIL mid_first: got %h want aa", d); end
    for (int c = 0; c < 4; c++) begin
      cycle(pu, po, d);
      total++; if (po !== 1'b0) begin bad++; $display("FAIL mid_stale: got %h want no word", d); end
    end
    bus.m_ready = 1'b0;
    sb.delete();
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
